// File: rtl/inst_mem_bank_pkg.sv
// inst_mem_bank_pkg: shared defaults, the fetch NOP word and the loader FSM encoding
package inst_mem_bank_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH_DEF = 4096;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;
  typedef enum logic {LOAD, RUN} state_e;
endpackage

// File: rtl/inst_mem_bank_if.sv
// inst_mem_bank_if: loader, runtime write and fetch signals of the instruction memory
interface inst_mem_bank_if import inst_mem_bank_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();
  logic ld_valid, ld_ready, ld_last, boot_done;
  logic [DATA_W-1:0] ld_data;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_rsp_data;
  modport master (
    output ld_valid, ld_data, ld_last, wr_en, wr_addr, wr_data, wr_be, f_req_valid, f_addr, f_rsp_ready,
    input ld_ready, boot_done, f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err
  );
  modport slave (
    input ld_valid, ld_data, ld_last, wr_en, wr_addr, wr_data, wr_be, f_req_valid, f_addr, f_rsp_ready,
    output ld_ready, boot_done, f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err
  );
endinterface

// File: rtl/inst_mem_bank_ram.sv
// inst_mem_bank_ram: byte-enabled write port and registered read port, contents never reset
module inst_mem_bank_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/inst_mem_bank.sv
// inst_mem_bank: boot loader FSM, runtime byte writes and a 1-cycle valid/ready fetch port
// with write-first forwarding and out-of-range NOP responses.
module inst_mem_bank import inst_mem_bank_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input logic clk,
  input logic rst_n,
  inst_mem_bank_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(DEPTH - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic ld_ready_q, ld_ready_d, boot_done_q, boot_done_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_live_q, rsp_live_d;
  logic [BE_W-1:0] fwd_be_q, fwd_be_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic ld_fire, wr_ok, f_ok, req_ready, accept, ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, merged;
  logic [BE_W-1:0] ram_be;
  always_comb begin
    ld_fire = bus.ld_valid & ld_ready_q;
    wr_ok = (state_q == RUN) & bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH_A);
    f_ok = {1'b0, bus.f_addr} < DEPTH_A;
    req_ready = (state_q == RUN) & (!rsp_valid_q | bus.f_rsp_ready);
    accept = bus.f_req_valid & req_ready;
    ram_we = ld_fire | wr_ok;
    ram_waddr = state_q == LOAD ? ld_ptr_q[IDX_W-1:0] : bus.wr_addr[IDX_W-1:0];
    ram_wdata = state_q == LOAD ? bus.ld_data : bus.wr_data;
    ram_be = state_q == LOAD ? '1 : bus.wr_be;
    state_d = (state_q == LOAD) && ld_fire && (bus.ld_last || {1'b0, ld_ptr_q} == LAST_A) ? RUN : state_q;
    ld_ptr_d = ld_fire ? ld_ptr_q + ADDR_W'(1) : ld_ptr_q;
    ld_ready_d = state_d == LOAD;
    boot_done_d = state_d == RUN;
    rsp_valid_d = accept | (rsp_valid_q & !bus.f_rsp_ready);
    rsp_err_d = accept ? !f_ok : rsp_err_q;
    rsp_live_d = rsp_live_q | accept;
    // the RAM returns pre-write data, so same-cycle write bytes are overlaid at the output
    fwd_be_d = accept ? (wr_ok && bus.wr_addr == bus.f_addr ? bus.wr_be : '0) : fwd_be_q;
    fwd_data_d = accept ? bus.wr_data : fwd_data_q;
  end
  for (genvar i = 0; i < BE_W; i++)
    assign merged[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8] : ram_rdata[8*i +: 8];
  always_comb begin
    bus.ld_ready = ld_ready_q;
    bus.boot_done = boot_done_q;
    bus.f_req_ready = req_ready;
    bus.f_rsp_valid = rsp_valid_q;
    bus.f_rsp_err = rsp_err_q;
    bus.f_rsp_data = !rsp_live_q ? '0 : rsp_err_q ? NOP_WORD : merged;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      ld_ptr_q <= '0;
      ld_ready_q <= 1'b0;
      boot_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_live_q <= 1'b0;
      fwd_be_q <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q <= state_d;
      ld_ptr_q <= ld_ptr_d;
      ld_ready_q <= ld_ready_d;
      boot_done_q <= boot_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_live_q <= rsp_live_d;
      fwd_be_q <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
    end
  end
  inst_mem_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk(clk),
    .we(ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .be(ram_be),
    .re(accept & f_ok),
    .raddr(bus.f_addr[IDX_W-1:0]),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_inst_mem_bank.sv
// tb_inst_mem_bank: directed scenarios for boot load, byte writes, forwarding, stall,
// range handling, reset mid-load and full-depth load, with a small memory scoreboard.
module tb_inst_mem_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [16];
  logic [31:0] rd;
  logic rd_err;
  inst_mem_bank_if #(.DATA_W(32), .ADDR_W(12)) bus ();
  inst_mem_bank #(.DATA_W(32), .ADDR_W(12), .DEPTH(16), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.f_req_valid = 0; bus.f_addr = '0; bus.f_rsp_ready = 1;
  endtask
  task automatic wait_ld_ready(input string tag);
    int n = 0;
    while (bus.ld_ready !== 1'b1 && n < 10) begin step(); n++; end
    checks++;
    if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL %s ld_ready timeout: got %b expected 1", tag, bus.ld_ready); end
  endtask
  task automatic fetch1(input logic [11:0] a);
    bus.f_req_valid = 1; bus.f_addr = a;
    step();
    bus.f_req_valid = 0;
    rd = bus.f_rsp_data; rd_err = bus.f_rsp_err;
  endtask
  task automatic write1(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    step();
    bus.wr_en = 0;
  endtask
  task automatic test_reset;
    clear_inputs();
    #1 rst_n = 0;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready); end
    checks++; if (bus.boot_done !== 1'b0) begin errors++; $display("FAIL reset_boot_done: got %b expected 0", bus.boot_done); end
    checks++; if (bus.f_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.f_rsp_valid); end
    checks++; if (bus.f_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.f_rsp_data); end
    checks++; if (bus.f_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus.f_rsp_err); end
    checks++; if (bus.f_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.f_req_ready); end
    step(); step();
    rst_n = 1;
  endtask
  task automatic test_boot;
    wait_ld_ready("boot");
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1; bus.ld_data = 32'((i + 1) * 'h11); bus.ld_last = (i == 3);
      exp_mem[i] = 32'((i + 1) * 'h11);
      checks++; if (bus.boot_done !== 1'b0) begin errors++; $display("FAIL boot_early_%0d: got %b expected 0", i, bus.boot_done); end
      step();
    end
    bus.ld_valid = 0; bus.ld_last = 0;
    checks++; if (bus.boot_done !== 1'b1) begin errors++; $display("FAIL boot_done: got %b expected 1", bus.boot_done); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL boot_ld_ready: got %b expected 0", bus.ld_ready); end
    for (int i = 0; i < 4; i++) begin
      bus.f_req_valid = 1; bus.f_addr = 12'(i);
      checks++; if (bus.f_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready_%0d: got %b expected 1", i, bus.f_req_ready); end
      step();
      checks++; if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_data !== exp_mem[i]) begin errors++; $display("FAIL b2b_rsp_%0d: got v=%b %h expected v=1 %h", i, bus.f_rsp_valid, bus.f_rsp_data, exp_mem[i]); end
    end
    bus.f_req_valid = 0;
    step();
    checks++; if (bus.f_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_clear: got %b expected 0", bus.f_rsp_valid); end
  endtask
  task automatic test_byte_write;
    write1(12'd2, 32'hAABBCCDD, 4'b0101);
    exp_mem[2] = 32'h00BB00DD;
    fetch1(12'd2);
    checks++; if (rd !== 32'h00BB00DD || rd_err !== 1'b0) begin errors++; $display("FAIL byte_write: got %h err=%b expected 00bb00dd err=0", rd, rd_err); end
  endtask
  task automatic test_forward;
    write1(12'd5, 32'h12345678, 4'hF);
    bus.wr_en = 1; bus.wr_addr = 12'd5; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'hF;
    fetch1(12'd5);
    bus.wr_en = 0;
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_full: got %h expected deadbeef", rd); end
    bus.wr_en = 1; bus.wr_data = 32'hCAFEF00D; bus.wr_be = 4'b0011;
    fetch1(12'd5);
    bus.wr_en = 0;
    checks++; if (rd !== 32'hDEADF00D) begin errors++; $display("FAIL fwd_partial: got %h expected deadf00d", rd); end
    fetch1(12'd5);
    checks++; if (rd !== 32'hDEADF00D) begin errors++; $display("FAIL fwd_stored: got %h expected deadf00d", rd); end
    bus.f_rsp_ready = 0;
    write1(12'd5, 32'h0BADF00D, 4'hF);
    checks++; if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_data !== 32'hDEADF00D) begin errors++; $display("FAIL fwd_held: got v=%b %h expected v=1 deadf00d", bus.f_rsp_valid, bus.f_rsp_data); end
    bus.f_rsp_ready = 1;
    step();
    exp_mem[5] = 32'h0BADF00D;
    fetch1(12'd5);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL fwd_after_hold: got %h expected 0badf00d", rd); end
  endtask
  task automatic test_stall;
    bus.f_req_valid = 1; bus.f_addr = 12'd0;
    step();
    bus.f_rsp_ready = 0; bus.f_addr = 12'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.f_req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready_%0d: got %b expected 0", i, bus.f_req_ready); end
      step();
      checks++; if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_data !== exp_mem[0]) begin errors++; $display("FAIL stall_hold_%0d: got v=%b %h expected v=1 %h", i, bus.f_rsp_valid, bus.f_rsp_data, exp_mem[0]); end
    end
    bus.f_rsp_ready = 1;
    #1;
    checks++; if (bus.f_req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", bus.f_req_ready); end
    step();
    checks++; if (bus.f_rsp_data !== exp_mem[1]) begin errors++; $display("FAIL stall_next1: got %h expected %h", bus.f_rsp_data, exp_mem[1]); end
    bus.f_addr = 12'd2;
    step();
    checks++; if (bus.f_rsp_data !== exp_mem[2]) begin errors++; $display("FAIL stall_next2: got %h expected %h", bus.f_rsp_data, exp_mem[2]); end
    bus.f_req_valid = 0;
    step();
    checks++; if (bus.f_rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", bus.f_rsp_valid); end
  endtask
  task automatic test_range;
    fetch1(12'd20);
    checks++; if (rd_err !== 1'b1 || rd !== 32'h00000013) begin errors++; $display("FAIL range_fetch: got err=%b %h expected err=1 00000013", rd_err, rd); end
    fetch1(12'd3);
    checks++; if (rd_err !== 1'b0 || rd !== exp_mem[3]) begin errors++; $display("FAIL range_recover: got err=%b %h expected err=0 %h", rd_err, rd, exp_mem[3]); end
    write1(12'd4, 32'h44440004, 4'hF);
    exp_mem[4] = 32'h44440004;
    bus.wr_en = 1; bus.wr_addr = 12'd20; bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'hF;
    fetch1(12'd4);
    bus.wr_en = 0;
    checks++; if (rd !== exp_mem[4]) begin errors++; $display("FAIL range_no_alias_fwd: got %h expected %h", rd, exp_mem[4]); end
    fetch1(12'd4);
    checks++; if (rd !== exp_mem[4]) begin errors++; $display("FAIL range_write_dropped: got %h expected %h", rd, exp_mem[4]); end
  endtask
  task automatic test_reload;
    rst_n = 0;
    step();
    rst_n = 1;
    wait_ld_ready("reload_a");
    bus.f_req_valid = 1; bus.f_addr = 12'd0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1; bus.ld_data = 32'hA0 + 32'(i);
      step();
    end
    bus.ld_valid = 0;
    checks++; if (bus.f_req_ready !== 1'b0) begin errors++; $display("FAIL reload_req_blocked_a: got %b expected 0", bus.f_req_ready); end
    rst_n = 0;
    #1;
    checks++; if (bus.ld_ready !== 1'b0 || bus.boot_done !== 1'b0) begin errors++; $display("FAIL reload_async_reset: got ld_ready=%b boot_done=%b expected 0 0", bus.ld_ready, bus.boot_done); end
    step();
    rst_n = 1;
    bus.wr_en = 1; bus.wr_addr = 12'd3; bus.wr_data = 32'h0; bus.wr_be = 4'hF;
    wait_ld_ready("reload_b");
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1; bus.ld_data = 32'hB0 + 32'(i); bus.ld_last = (i == 2);
      exp_mem[i] = 32'hB0 + 32'(i);
      checks++; if (bus.f_req_ready !== 1'b0 || bus.boot_done !== 1'b0) begin errors++; $display("FAIL reload_during_%0d: got req_ready=%b boot_done=%b expected 0 0", i, bus.f_req_ready, bus.boot_done); end
      step();
    end
    bus.ld_valid = 0; bus.ld_last = 0; bus.wr_en = 0; bus.f_req_valid = 0;
    step();
    checks++; if (bus.boot_done !== 1'b1) begin errors++; $display("FAIL reload_boot_done: got %b expected 1", bus.boot_done); end
    for (int i = 0; i < 4; i++) begin
      fetch1(12'(i));
      checks++; if (rd !== exp_mem[i]) begin errors++; $display("FAIL reload_word_%0d: got %h expected %h", i, rd, exp_mem[i]); end
    end
  endtask
  task automatic test_full_load;
    rst_n = 0;
    step();
    rst_n = 1;
    wait_ld_ready("full");
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1; bus.ld_data = 32'h100 + 32'(i);
      exp_mem[i] = 32'h100 + 32'(i);
      if (i == 15) begin
        checks++; if (bus.boot_done !== 1'b0) begin errors++; $display("FAIL full_early: got %b expected 0", bus.boot_done); end
      end
      step();
    end
    bus.ld_data = 32'hFFFFFFFF;
    checks++; if (bus.boot_done !== 1'b1 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL full_boot_done: got boot_done=%b ld_ready=%b expected 1 0", bus.boot_done, bus.ld_ready); end
    step();
    bus.ld_valid = 0;
    fetch1(12'd0);
    checks++; if (rd !== exp_mem[0]) begin errors++; $display("FAIL full_word0: got %h expected %h", rd, exp_mem[0]); end
    fetch1(12'd15);
    checks++; if (rd !== exp_mem[15]) begin errors++; $display("FAIL full_word15: got %h expected %h", rd, exp_mem[15]); end
  endtask
  initial begin
    test_reset();
    test_boot();
    test_byte_write();
    test_forward();
    test_stall();
    test_range();
    test_reload();
    test_full_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
